imem_loader: RTL

//  Boot-time writer for the RISC-V core's instruction memory: receives a byte stream over a

---
 rtl/imem_loader_pkg.sv | 6 +
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 100 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths and FSM state encoding for the instruction-memory loader.
package imem_loader_pkg;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} loader_state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: shifts bytes in LSB-first and flags the push that completes a word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);
    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] sr_q, sr_d;

    // word_o shows the word including the byte being pushed, so the full word is usable at the completing edge
    always_comb begin
        sr_d  = clear_i ? '0 : push_i ? {byte_i, sr_q[WORD_W-1:BYTE_W]} : sr_q;
        cnt_d = clear_i ? '0 : push_i ? cnt_q + 2'd1 : cnt_q;
    end

    assign word_o      = sr_d;
    assign word_full_o = push_i && !clear_i && (cnt_q == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that writes a length-prefixed little-endian byte stream into
// instruction memory and holds the core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int              ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_loaded_o
);
    localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_W) - 33'(BASE_ADDR);

    loader_state_t     state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              go, push, word_full;
    logic [WORD_W-1:0] word;

    assign in_ready_o     = (state_q == LEN) || (state_q == DATA);
    assign mem_we_o       = (state_q == WRITE);
    assign cpu_hold_o     = (state_q != DONE);
    assign done_o         = (state_q == DONE);
    assign err_o          = (state_q == ERR);
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;
    assign words_loaded_o = words_q;
    assign go             = start_i && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign push           = in_valid_i && in_ready_o;

    imem_loader_byte_packer u_packer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (go),
        .push_i     (push),
        .byte_i     (in_data_i),
        .word_o     (word),
        .word_full_o(word_full)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        words_d = words_q;
        wdata_d = wdata_q;
        if (go) begin
            state_d = LEN;
            len_d   = '0;
            addr_d  = BASE_ADDR;
            words_d = '0;
        end else begin
            case (state_q)
                LEN: if (word_full) begin
                    len_d   = word;
                    state_d = (word == '0) ? DONE : ({1'b0, word} > MAX_WORDS) ? ERR : DATA;
                end
                DATA: if (word_full) begin
                    wdata_d = word;
                    state_d = WRITE;
                end
                WRITE: begin
                    words_d = words_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                    state_d = (32'(words_q) + 32'd1 == len_q) ? DONE : DATA;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            words_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            wdata_q <= wdata_d;
        end
    end
endmodule
